// File: rtl/pll_lpf_autotuner.sv
// pll_lpf_autotuner
//   Sweeps charge-pump current / loop-filter resistor settings for each PLL
//   channel in turn. Each candidate gets a PLL reset pulse, a timed wait for
//   lock and a stability window. The fastest stable candidate is then applied.
//   A channel with no stable candidate is flagged and gets the defaults.
//   All logic runs on the PLL reference clock.
//
// Ports
//   clkin      reference clock (same clock as the PLLs)
//   reset      asynchronous active-high reset
//   start      single-cycle request to tune all channels (ignored while busy)
//   pll_lock   raw, asynchronous PLL lock indications, one per channel
//   pll_reset  PLL reset controls; only the channel under tuning ever pulses
//   icpsel     6 bits per channel, channel k at [6k+5:6k]
//   lpfres     3 bits per channel, channel k at [3k+2:3k]
//   lpfcap     2 bits per channel, constant LPF_CAP_VAL
//   busy       tuning in progress
//   done       sweep complete; held until the next accepted start or reset
//   fail       per channel: no stable candidate was found
module pll_lpf_autotuner #(
  parameter int unsigned NUM_PLL       = 1,
  parameter int unsigned ICP_MIN       = 1,
  parameter int unsigned ICP_MAX       = 31,
  parameter int unsigned ICP_STEP      = 2,
  parameter int unsigned RES_MAX       = 7,
  parameter int unsigned LPF_CAP_VAL   = 0,
  parameter int unsigned DEF_ICP       = 16,
  parameter int unsigned DEF_RES       = 2,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4095,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic                   clkin,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLL-1:0]     pll_lock,
  output logic [NUM_PLL-1:0]     pll_reset,
  output logic [6*NUM_PLL-1:0]   icpsel,
  output logic [3*NUM_PLL-1:0]   lpfres,
  output logic [2*NUM_PLL-1:0]   lpfcap,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_PLL-1:0]     fail
);

  localparam int unsigned CH_W    = $clog2(NUM_PLL + 1);
  localparam int unsigned CNT_MAX =
    (RST_CYCLES > LOCK_TIMEOUT) ?
      ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES) :
      ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LT_W    = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [5:0] ICP_MIN6 = 6'(ICP_MIN);
  localparam logic [5:0] DEF_ICP6 = 6'(DEF_ICP);
  localparam logic [2:0] DEF_RES3 = 3'(DEF_RES);
  localparam logic [2:0] RES_MAX3 = 3'(RES_MAX);

  typedef enum logic [2:0] {
    IDLE, TRIAL_RST, WAIT_LOCK, STABLE, NEXT, APPLY_RST, APPLY_WAIT, DONE
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   ch;
  logic [CH_W-1:0]   ch_nxt;
  logic [5:0]        icp;
  logic [6:0]        icp_nxt;
  logic [2:0]        res;
  logic              best_valid;
  logic [5:0]        best_icp;
  logic [2:0]        best_res;
  logic [LT_W-1:0]   best_t;
  logic [LT_W-1:0]   lock_t;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_PLL-1:0] lock_meta;
  logic [NUM_PLL-1:0] lock_sync;
  logic              lock_cur;

  assign lpfcap  = {NUM_PLL{2'(LPF_CAP_VAL)}};
  assign ch_nxt  = ch + CH_W'(1);
  // one extra bit so a step past 63 is caught as exceeding ICP_MAX
  assign icp_nxt = {1'b0, icp} + 7'(ICP_STEP);

  function automatic logic [NUM_PLL-1:0] ch_mask(input logic [CH_W-1:0] c);
    logic [NUM_PLL-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < NUM_PLL; k++)
      if (CH_W'(k) == c) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [6*NUM_PLL-1:0] put_icp(input logic [6*NUM_PLL-1:0] v,
                                                   input logic [CH_W-1:0] c,
                                                   input logic [5:0] x);
    for (int unsigned k = 0; k < NUM_PLL; k++)
      if (CH_W'(k) == c) v[6*k +: 6] = x;
    return v;
  endfunction

  function automatic logic [3*NUM_PLL-1:0] put_res(input logic [3*NUM_PLL-1:0] v,
                                                   input logic [CH_W-1:0] c,
                                                   input logic [2:0] x);
    for (int unsigned k = 0; k < NUM_PLL; k++)
      if (CH_W'(k) == c) v[3*k +: 3] = x;
    return v;
  endfunction

  always_comb begin
    lock_cur = 1'b0;
    for (int unsigned k = 0; k < NUM_PLL; k++)
      if (CH_W'(k) == ch) lock_cur = lock_sync[k];
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_sync <= lock_meta;
    end
  end

  // Settings and pll_reset are updated on the edge that enters a *_RST state,
  // so cnt starts at 1 and the pulse is exactly RST_CYCLES wide.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      icp        <= '0;
      res        <= '0;
      best_valid <= 1'b0;
      best_icp   <= '0;
      best_res   <= '0;
      best_t     <= '0;
      lock_t     <= '0;
      cnt        <= '0;
      pll_reset  <= '0;
      icpsel     <= {NUM_PLL{DEF_ICP6}};
      lpfres     <= {NUM_PLL{DEF_RES3}};
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ch         <= '0;
            icp        <= ICP_MIN6;
            res        <= '0;
            best_valid <= 1'b0;
            done       <= 1'b0;
            fail       <= '0;
            busy       <= 1'b1;
            icpsel     <= put_icp(icpsel, '0, ICP_MIN6);
            lpfres     <= put_res(lpfres, '0, 3'd0);
            pll_reset  <= ch_mask('0);
            cnt        <= CNT_W'(1);
            state      <= TRIAL_RST;
          end
        end
        TRIAL_RST: begin
          if (cnt == CNT_W'(RST_CYCLES)) begin
            pll_reset <= '0;
            cnt       <= CNT_W'(1);
            state     <= WAIT_LOCK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_cur) begin
            lock_t <= LT_W'(cnt);
            cnt    <= CNT_W'(1);
            state  <= STABLE;
          end else if (cnt == CNT_W'(LOCK_TIMEOUT)) begin
            state <= NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lock_cur) begin
            state <= NEXT;
          end else if (cnt == CNT_W'(STABLE_CYCLES)) begin
            // strict compare: on a tie the earlier candidate is kept
            if (!best_valid || lock_t < best_t) begin
              best_valid <= 1'b1;
              best_icp   <= icp;
              best_res   <= res;
              best_t     <= lock_t;
            end
            state <= NEXT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        NEXT: begin
          cnt       <= CNT_W'(1);
          pll_reset <= ch_mask(ch);
          if (res != RES_MAX3) begin
            res    <= res + 3'd1;
            lpfres <= put_res(lpfres, ch, res + 3'd1);
            state  <= TRIAL_RST;
          end else if (icp_nxt <= 7'(ICP_MAX)) begin
            icp    <= icp_nxt[5:0];
            res    <= '0;
            icpsel <= put_icp(icpsel, ch, icp_nxt[5:0]);
            lpfres <= put_res(lpfres, ch, 3'd0);
            state  <= TRIAL_RST;
          end else if (best_valid) begin
            icpsel <= put_icp(icpsel, ch, best_icp);
            lpfres <= put_res(lpfres, ch, best_res);
            state  <= APPLY_RST;
          end else begin
            fail   <= fail | ch_mask(ch);
            icpsel <= put_icp(icpsel, ch, DEF_ICP6);
            lpfres <= put_res(lpfres, ch, DEF_RES3);
            state  <= APPLY_RST;
          end
        end
        APPLY_RST: begin
          if (cnt == CNT_W'(RST_CYCLES)) begin
            pll_reset <= '0;
            cnt       <= CNT_W'(1);
            state     <= APPLY_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        APPLY_WAIT: begin
          if (lock_cur || cnt == CNT_W'(LOCK_TIMEOUT)) begin
            ch <= ch_nxt;
            if (ch_nxt == CH_W'(NUM_PLL)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              icp        <= ICP_MIN6;
              res        <= '0;
              best_valid <= 1'b0;
              icpsel     <= put_icp(icpsel, ch_nxt, ICP_MIN6);
              lpfres     <= put_res(lpfres, ch_nxt, 3'd0);
              pll_reset  <= ch_mask(ch_nxt);
              cnt        <= CNT_W'(1);
              state      <= TRIAL_RST;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lpf_autotuner.sv
// Testbench for pll_lpf_autotuner: two channels, reduced timeout/stability
// windows, a behavioural PLL plant per channel and an independent sweep model.
module tb_pll_lpf_autotuner;

  localparam int NP       = 2;
  localparam int ICP_MIN  = 1;
  localparam int ICP_MAX  = 31;
  localparam int ICP_STEP = 2;
  localparam int RES_MAX  = 7;
  localparam int CAP      = 1;
  localparam int DEF_ICP  = 16;
  localparam int DEF_RES  = 2;
  localparam int RST_CYC  = 16;
  localparam int LTO      = 100;
  localparam int STAB     = 32;
  localparam int N_TRIAL  = ((ICP_MAX - ICP_MIN) / ICP_STEP + 1) * (RES_MAX + 1);

  logic              clk;
  logic              rst;
  logic              start;
  logic [NP-1:0]     pll_lock;
  logic [NP-1:0]     pll_reset;
  logic [6*NP-1:0]   icpsel;
  logic [3*NP-1:0]   lpfres;
  logic [2*NP-1:0]   lpfcap;
  logic              busy;
  logic              done;
  logic [NP-1:0]     fail;

  int checks = 0;
  int errors = 0;
  int scen   = 0;

  int exp_icp  [NP];
  int exp_res  [NP];
  int exp_fail [NP];

  int trials    [NP];
  int width     [NP];
  int last_fall [NP];
  int cur_ch;
  int cyc;
  logic [NP-1:0] prev_pr;

  pll_lpf_autotuner #(
    .NUM_PLL(NP), .ICP_MIN(ICP_MIN), .ICP_MAX(ICP_MAX), .ICP_STEP(ICP_STEP),
    .RES_MAX(RES_MAX), .LPF_CAP_VAL(CAP), .DEF_ICP(DEF_ICP), .DEF_RES(DEF_RES),
    .RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(LTO), .STABLE_CYCLES(STAB)
  ) dut (
    .clkin(clk), .reset(rst), .start(start), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap),
    .busy(busy), .done(done), .fail(fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int cand_icp(input int n);
    return ICP_MIN + ICP_STEP * (n / (RES_MAX + 1));
  endfunction

  function automatic int cand_res(input int n);
    return n % (RES_MAX + 1);
  endfunction

  // Lock latency in cycles after PLL reset release; -1 means never locks.
  function automatic int lat_of(input int sc, input int k, input int i, input int r);
    int l;
    l = 20;
    if (sc == 1 && k == 0) begin
      if (i < 5) l = -1;
      else if (i == 9 && r == 3) l = 10;
      else l = 40;
    end else if (sc == 1 && k == 1) begin
      if ((i == 13 && r == 5) || (i == 21 && r == 1)) l = 10;
    end else if (sc == 2 && k == 0) begin
      l = -1;
    end else if (sc == 2 && k == 1) begin
      if (i == 9 && r == 3) l = 10;
      else if (i == 11 && r == 0) l = 12;
    end
    return l;
  endfunction

  // Cycles after first lock assertion at which lock drops; -1 means never.
  function automatic int drop_of(input int sc, input int k, input int i, input int r);
    if (sc == 2 && k == 1 && i == 9 && r == 3) return 20;
    return -1;
  endfunction

  task automatic model_best(input int sc, input int k, output int bi, output int br, output int bf);
    int best;
    int l;
    int d;
    best = -1;
    bi = DEF_ICP;
    br = DEF_RES;
    bf = 1;
    for (int n = 0; n < N_TRIAL; n++) begin
      l = lat_of(sc, k, cand_icp(n), cand_res(n));
      d = drop_of(sc, k, cand_icp(n), cand_res(n));
      if (l >= 0 && l + 3 <= LTO && (d < 0 || d > STAB + 3) && (best < 0 || l < best)) begin
        best = l;
        bi = cand_icp(n);
        br = cand_res(n);
        bf = 0;
      end
    end
  endtask

  task automatic set_scen(input int sc);
    scen = sc;
    for (int k = 0; k < NP; k++) model_best(sc, k, exp_icp[k], exp_res[k], exp_fail[k]);
  endtask

  // PLL plant: latches settings while held in reset, locks after its latency.
  initial begin : plant
    int pc [NP];
    int pi [NP];
    int pr [NP];
    int l;
    int d;
    logic [NP-1:0] lk;
    pll_lock = '0;
    for (int k = 0; k < NP; k++) begin pc[k] = 0; pi[k] = 0; pr[k] = 0; end
    forever begin
      @(posedge clk);
      #1;
      lk = '0;
      for (int k = 0; k < NP; k++) begin
        if (rst || pll_reset[k]) begin
          pc[k] = 0;
          if (pll_reset[k]) begin
            pi[k] = int'(icpsel[6*k +: 6]);
            pr[k] = int'(lpfres[3*k +: 3]);
          end
        end else begin
          pc[k]++;
          l = lat_of(scen, k, pi[k], pr[k]);
          d = drop_of(scen, k, pi[k], pr[k]);
          lk[k] = (l >= 0) && (pc[k] >= l) && !((d >= 0) && (pc[k] >= l + d));
        end
      end
      pll_lock = lk;
    end
  end

  // Per-cycle compare against the sweep model.
  initial begin : monitor
    int n;
    int pn;
    cur_ch = 0;
    cyc = 0;
    prev_pr = '0;
    for (int k = 0; k < NP; k++) begin trials[k] = 0; width[k] = 0; last_fall[k] = 0; end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cur_ch = 0;
        prev_pr = '0;
        for (int k = 0; k < NP; k++) begin trials[k] = 0; width[k] = 0; last_fall[k] = 0; end
      end else begin
        chk("lpfcap", lpfcap, 4'b0101);
        chk("one_reset_high", ($countones(pll_reset) <= 1) ? 1 : 0, 1);
        chk("busy_done_excl", (busy && done) ? 1 : 0, 0);
        if (pll_reset != '0) chk("busy_during_pulse", busy, 1);
        for (int k = 0; k < NP; k++) begin
          if (pll_reset[k]) width[k]++;
          if (!pll_reset[k] && prev_pr[k]) begin
            chk("pulse_width", width[k], RST_CYC);
            width[k] = 0;
            last_fall[k] = cyc;
          end
          if (pll_reset[k] && !prev_pr[k]) begin
            if (k < cur_ch) begin
              chk("channel_order", k, cur_ch);
            end else if (k > cur_ch) begin
              chk("prev_channel_pulses", trials[cur_ch], N_TRIAL + 1);
              cur_ch = k;
            end
            n = trials[k];
            if (n < N_TRIAL) begin
              chk("trial_icp", icpsel[6*k +: 6], cand_icp(n));
              chk("trial_res", lpfres[3*k +: 3], cand_res(n));
            end else if (n == N_TRIAL) begin
              chk("apply_icp", icpsel[6*k +: 6], exp_icp[k]);
              chk("apply_res", lpfres[3*k +: 3], exp_res[k]);
            end else begin
              chk("extra_pulse", n, N_TRIAL);
            end
            if (n > 0 && n <= N_TRIAL) begin
              pn = n - 1;
              if (lat_of(scen, k, cand_icp(pn), cand_res(pn)) < 0)
                chk("timeout_gap", cyc - last_fall[k], LTO + 1);
            end
            trials[k]++;
          end
        end
        for (int k = 0; k < NP; k++) begin
          if (k < cur_ch) begin
            chk("done_ch_icp", icpsel[6*k +: 6], exp_icp[k]);
            chk("done_ch_res", lpfres[3*k +: 3], exp_res[k]);
            chk("done_ch_fail", fail[k], exp_fail[k]);
          end else if (k > cur_ch) begin
            chk("idle_ch_icp", icpsel[6*k +: 6], DEF_ICP);
            chk("idle_ch_res", lpfres[3*k +: 3], DEF_RES);
            chk("idle_ch_fail", fail[k], 0);
          end
        end
        prev_pr = pll_reset;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin : main
    int n;
    rst = 1'b1;
    start = 1'b0;
    set_scen(1);
    repeat (3) @(negedge clk);
    chk("rst_pll_reset", pll_reset, 0);
    chk("rst_icpsel", icpsel, 12'h410);
    chk("rst_lpfres", lpfres, 6'h12);
    chk("rst_lpfcap", lpfcap, 4'b0101);
    chk("rst_flags", {busy, done, fail}, 4'b0000);
    #2 rst = 1'b0;

    // Scenario 1: best-setting selection on ch0, tie-break on ch1, ignored restart
    repeat (5) @(negedge clk);
    pulse_start();
    chk("s1_busy_after_start", busy, 1);
    repeat (3000) @(negedge clk);
    chk("s1_busy_mid", busy, 1);
    pulse_start();
    wait_done(40000);
    chk("s1_icp0", icpsel[5:0], 9);
    chk("s1_res0", lpfres[2:0], 3);
    chk("s1_icp1", icpsel[11:6], 13);
    chk("s1_res1", lpfres[5:3], 5);
    chk("s1_fail", fail, 0);
    chk("s1_busy_end", busy, 0);
    chk("s1_trials0", trials[0], 129);
    chk("s1_trials1", trials[1], 129);
    repeat (5) @(negedge clk);
    chk("s1_done_held", done, 1);
    chk("s1_no_pulse_after", pll_reset, 0);

    // Scenario 2: ch0 never locks, ch1 fastest candidate unstable
    do_reset();
    set_scen(2);
    pulse_start();
    wait_done(40000);
    chk("s2_fail", fail, 2'b01);
    chk("s2_icp0", icpsel[5:0], 16);
    chk("s2_res0", lpfres[2:0], 2);
    chk("s2_icp1", icpsel[11:6], 11);
    chk("s2_res1", lpfres[5:3], 0);
    chk("s2_done", done, 1);
    chk("s2_trials0", trials[0], 129);

    // Scenario 3: reset mid-pulse, then idle without start
    do_reset();
    set_scen(3);
    pulse_start();
    n = 0;
    while (!pll_reset[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("s3_pulse_seen", pll_reset[0], 1);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("s3_async_pll_reset", pll_reset, 0);
    chk("s3_async_busy", busy, 0);
    chk("s3_async_icpsel", icpsel, 12'h410);
    chk("s3_async_lpfres", lpfres, 6'h12);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      chk("s3_static", {pll_reset, icpsel, lpfres, busy, done, fail},
          {2'b00, 12'h410, 6'h12, 1'b0, 1'b0, 2'b00});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
